// File: rtl/mic1_mem_pkg.sv
// Shared types and helpers for the Mic-1 main-memory responder.
package mic1_mem_pkg;

  typedef enum logic {LOAD, RUN} mem_state_e;

  localparam logic [31:0] IO_OUT_ADDR_DEF = 32'h0000_FFFF;
  localparam logic [31:0] IO_IN_ADDR_DEF  = 32'h0000_FFFE;

  // Big-endian lane pick: lane 0 is the most significant byte.
  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mic1_memory_if.sv
// Bus bundle between the host loader / Mic-1 core (master) and mic1_memory (slave).
interface mic1_memory_if;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        load_last;
  logic        run;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_fetch;
  logic [31:0] mem_addr_instr;
  logic [7:0]  mem_rd_instr;
  logic [31:0] io_in;
  logic [31:0] io_out;
  logic        io_out_valid;

  modport master (
    output load_valid, load_data, load_last, mem_addr, mem_wdata, mem_read,
           mem_write, mem_fetch, mem_addr_instr, io_in,
    input  load_ready, run, mem_rdata, mem_rd_instr, io_out, io_out_valid
  );

  modport slave (
    input  load_valid, load_data, load_last, mem_addr, mem_wdata, mem_read,
           mem_write, mem_fetch, mem_addr_instr, io_in,
    output load_ready, run, mem_rdata, mem_rd_instr, io_out, io_out_valid
  );
endinterface

// File: rtl/mic1_word_ram.sv
// Word RAM: one synchronous write port, two asynchronous read ports (data and fetch).
module mic1_word_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  input  logic [AW-1:0] fe_addr_i,
  output logic [31:0]   fe_data_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];
  assign fe_data_o = mem_q[fe_addr_i];

endmodule

// File: rtl/mic1_memory.sv
// Mic-1 main memory: byte-stream loader, word data port, byte fetch port, I/O registers.
// Optional MIC1_MEM_ADDR_CHECK_EN adds sticky addr_err / err_addr out-of-range reporting.
module mic1_memory
  import mic1_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF,
  parameter logic [31:0] IO_IN_ADDR  = IO_IN_ADDR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mic1_memory_if.slave  bus
`ifdef MIC1_MEM_ADDR_CHECK_EN
  ,
  output logic          addr_err,
  output logic [31:0]   err_addr
`endif
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  mem_state_e  state_q;
  logic [31:0] ptr_q;
  logic [23:0] pack_q;
  logic [23:0] pack_d;
  logic [31:0] io_out_q;
  logic        io_out_valid_q;

  logic        run_w, ld_fire, ld_in_range, ld_word_done;
  logic [31:0] ld_word;
  logic        d_in_range, f_in_range, core_we, io_wr;
  logic        ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0] ram_wdata, ram_rd, ram_fe;

  assign run_w        = (state_q == RUN);
  assign ld_fire      = (state_q == LOAD) && bus.load_valid;
  assign ld_in_range  = {2'b00, ptr_q[31:2]} < DEPTH_L;
  assign ld_word_done = ld_fire && ld_in_range && ((ptr_q[1:0] == 2'd3) || bus.load_last);
  assign pack_d       = {pack_q[15:0], bus.load_data};

  // A short final word is left-aligned so earlier bytes land in the high lanes.
  always_comb begin
    case (ptr_q[1:0])
      2'd0:    ld_word = {bus.load_data, 24'h0};
      2'd1:    ld_word = {pack_q[7:0], bus.load_data, 16'h0};
      2'd2:    ld_word = {pack_q[15:0], bus.load_data, 8'h0};
      default: ld_word = {pack_q, bus.load_data};
    endcase
  end

  assign d_in_range = bus.mem_addr < DEPTH_L;
  assign f_in_range = {2'b00, bus.mem_addr_instr[31:2]} < DEPTH_L;
  assign core_we    = run_w && bus.mem_write && d_in_range;
  assign io_wr      = run_w && bus.mem_write && (bus.mem_addr == IO_OUT_ADDR);

  assign ram_we    = ld_word_done || core_we;
  assign ram_waddr = run_w ? bus.mem_addr[AW-1:0] : ptr_q[AW+1:2];
  assign ram_wdata = run_w ? bus.mem_wdata : ld_word;

  mic1_word_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .rd_addr_i (bus.mem_addr[AW-1:0]),
    .rd_data_o (ram_rd),
    .fe_addr_i (bus.mem_addr_instr[AW+1:2]),
    .fe_data_o (ram_fe)
  );

  always_comb begin
    bus.mem_rdata = 32'h0;
    if (run_w && bus.mem_read) begin
      if (d_in_range)                     bus.mem_rdata = ram_rd;
      else if (bus.mem_addr == IO_IN_ADDR) bus.mem_rdata = bus.io_in;
    end
  end

  always_comb begin
    bus.mem_rd_instr = 8'h00;
    if (run_w && bus.mem_fetch && f_in_range)
      bus.mem_rd_instr = lane_sel(ram_fe, bus.mem_addr_instr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LOAD;
      ptr_q          <= 32'h0;
      pack_q         <= 24'h0;
      io_out_q       <= 32'h0;
      io_out_valid_q <= 1'b0;
    end else begin
      io_out_valid_q <= io_wr;
      if (io_wr) io_out_q <= bus.mem_wdata;
      case (state_q)
        LOAD: begin
          if (ld_fire) begin
            pack_q <= pack_d;
            if (ptr_q != 32'hFFFF_FFFF) ptr_q <= ptr_q + 32'd1;
            if (bus.load_last) state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.load_ready   = (state_q == LOAD);
  assign bus.run          = run_w;
  assign bus.io_out       = io_out_q;
  assign bus.io_out_valid = io_out_valid_q;

`ifdef MIC1_MEM_ADDR_CHECK_EN
  logic        err_q;
  logic [31:0] err_addr_q;
  logic        d_err, f_err;

  assign d_err = run_w && (bus.mem_read || bus.mem_write) && !d_in_range &&
                 (bus.mem_addr != IO_IN_ADDR) && (bus.mem_addr != IO_OUT_ADDR);
  assign f_err = run_w && bus.mem_fetch && !f_in_range;

  // Only the first offending address is kept; data-port errors win a same-cycle tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (!err_q && (d_err || f_err)) begin
      err_q      <= 1'b1;
      err_addr_q <= d_err ? bus.mem_addr : bus.mem_addr_instr;
    end
  end

  assign addr_err = err_q;
  assign err_addr = err_addr_q;
`endif

endmodule
